// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings in mux-select order, flag bit
// positions and the result-entry layout used by the result stage.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Result entry at the default datapath width; modules with a different
    // width build the same {data, sel, flags} layout from their own W.
    typedef struct packed {
        logic [ALU_W-1:0] data;
        logic [2:0]       sel;
        logic [3:0]       flags;
    } alu_entry_t;

    // C and V only carry meaning when the adder produced the result.
    function automatic logic isAddSub(input logic [2:0] sel);
        return (sel == OP_ADD) || (sel == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU mux, the result stage and writeback.
// The slave modport is the stage's view; master is the surrounding logic.
interface alu_result_stage_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [2:0]   in_sel;
    logic         in_carry;
    logic         in_ovf;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   out_sel;
    logic [3:0]   out_flags;
    logic [3:0]   stat_flags;

    modport slave (
        input  in_valid, in_data, in_sel, in_carry, in_ovf, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_flags, stat_flags
    );

    modport master (
        output in_valid, in_data, in_sel, in_carry, in_ovf, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_flags, stat_flags
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V derivation from a result and the op that made it.
// Kept separate so the branch-compare path can reuse it.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] i_data,
    input  logic [2:0]   i_sel,
    input  logic         i_carry,
    input  logic         i_ovf,
    output logic [3:0]   o_flags
);

    // Carry and overflow are suppressed unless the adder was selected.
    always_comb begin
        o_flags         = 4'b0000;
        o_flags[FLAG_N] = i_data[W-1];
        o_flags[FLAG_Z] = (i_data == '0);
        o_flags[FLAG_C] = isAddSub(i_sel) & i_carry;
        o_flags[FLAG_V] = isAddSub(i_sel) & i_ovf;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: captures result + flags, presents them to
// writeback through a 2-entry skid buffer, and keeps a sticky status copy
// of the flags of the most recently delivered result.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_result_stage_if.slave     bus
);

    typedef struct packed {
        logic [W-1:0] data;
        logic [2:0]   sel;
        logic [3:0]   flags;
    } entry_t;

    entry_t     r_main;
    entry_t     r_skid;
    logic       r_mainValid;
    logic       r_skidValid;
    logic [3:0] r_statFlags;

    logic       w_accept;
    logic       w_deliver;
    logic [3:0] w_newFlags;
    entry_t     w_newEntry;

    alu_flag_gen #(.W(W)) u_flagGen (
        .i_data  (bus.in_data),
        .i_sel   (bus.in_sel),
        .i_carry (bus.in_carry),
        .i_ovf   (bus.in_ovf),
        .o_flags (w_newFlags)
    );

    // in_ready depends only on skid occupancy, so out_ready never reaches it
    // combinationally.
    assign w_accept  = bus.in_valid && !r_skidValid;
    assign w_deliver = r_mainValid && bus.out_ready;

    // Pack the incoming result with its freshly derived flags.
    always_comb begin
        w_newEntry       = '0;
        w_newEntry.data  = bus.in_data;
        w_newEntry.sel   = bus.in_sel;
        w_newEntry.flags = w_newFlags;
    end

    // Skid buffer: main drives the outputs, skid catches the one result that
    // arrives while main is stalled. Order stays FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main      <= '0;
            r_skid      <= '0;
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
        end else begin
            if (w_deliver) begin
                if (r_skidValid) begin
                    r_main      <= r_skid;
                    r_skidValid <= 1'b0;
                end else if (!w_accept) begin
                    r_mainValid <= 1'b0;
                end
            end
            if (w_accept) begin
                if (!r_mainValid || w_deliver) begin
                    r_main      <= w_newEntry;
                    r_mainValid <= 1'b1;
                end else begin
                    r_skid      <= w_newEntry;
                    r_skidValid <= 1'b1;
                end
            end
        end
    end

    // Sticky status: remember the flags of whatever writeback just took.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_statFlags <= 4'b0000;
        end else if (w_deliver) begin
            r_statFlags <= r_main.flags;
        end
    end

    assign bus.in_ready   = !r_skidValid;
    assign bus.out_valid  = r_mainValid;
    assign bus.out_data   = r_main.data;
    assign bus.out_sel    = r_main.sel;
    assign bus.out_flags  = r_main.flags;
    assign bus.stat_flags = r_statFlags;

endmodule
